// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and widths for the uart_tx transmitter
package uart_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - per-bit cycle counter; bit_done marks the last cycle of a serial bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_done = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-deep holding buffer
// Define UART_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datain,
  input  logic              wrsig,
  output logic              tx,
  output logic              idle,
  output logic              ovf
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [DATA_W-1:0]    buf_q, buf_d;
  logic [DATA_W-1:0]    load_byte;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 full_q, full_d;
  logic                 bit_done, restart, stop_end;
  logic                 take_direct, capture, drop, load;
  logic                 tx_d, idle_d;
`ifdef UART_PARITY_EN
  logic                 par_q, par_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Counter is held at zero while idle; every later transition lands on bit_done, where it wraps.
  assign restart = (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_done(bit_done)
  );

  always_comb begin
    stop_end    = (state_q == STOP) && bit_done;
    // A write landing on the final stop cycle with an empty buffer goes straight to the shifter.
    take_direct = wrsig && ((state_q == IDLE) || (stop_end && !full_q));
    capture     = wrsig && !take_direct && (!full_q || stop_end);
    drop        = wrsig && !take_direct && !capture;
    load        = take_direct || (stop_end && full_q);
    load_byte   = (stop_end && full_q) ? buf_q : datain;

    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    buf_d   = buf_q;
    full_d  = full_q;

    case (state_q)
      START: begin
        if (bit_done) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d = load_byte;
      bit_d   = '0;
      state_d = START;
    end
    if (stop_end && full_q) full_d = 1'b0;
    if (capture) begin
      buf_d  = datain;
      full_d = 1'b1;
    end

    idle_d = (state_d == IDLE) && !full_d;

`ifdef UART_PARITY_EN
    par_d = load ? (^load_byte ^ PARITY_ODD) : par_q;
`endif

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      buf_q   <= '0;
      bit_q   <= '0;
      full_q  <= 1'b0;
      tx      <= 1'b1;
      idle    <= 1'b1;
      ovf     <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      bit_q   <= bit_d;
      full_q  <= full_d;
      tx      <= tx_d;
      idle    <= idle_d;
      ovf     <= drop;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: directed writes, serial-line decoder monitor
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB  = 100;
  localparam bit PODD = 1'b0;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = CPB * NBITS;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       wrsig  = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       tx, idle, ovf;

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         skip;
  } exp_t;
  exp_t sb[$];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .datain(datain),
    .wrsig (wrsig),
    .tx    (tx),
    .idle  (idle),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_until(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  // mode: 0 no frame expected, 1 frame expected at exp_start, 2 frame starts but is aborted
  task automatic write_at(input int c, input logic [7:0] b, input int mode, input int exp_start);
    while (cyc != c) begin
      @(posedge clk);
      #1;
    end
    if (mode != 0) sb.push_back('{data: b, start: exp_start, skip: (mode == 2)});
    datain = b;
    wrsig  = 1'b1;
    @(posedge clk);
    #1;
    wrsig  = 1'b0;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] d;
    int         st;
    bit         have;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        st   = cyc;
        have = (sb.size() > 0);
        if (have) e = sb.pop_front();
        else chk("unexpected_frame", st, -1);
        repeat (CPB / 2) @(negedge clk);
        if (have && !e.skip) chk("start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        if (have && !e.skip) chk("parity_bit", tx, int'(^e.data ^ PODD));
`endif
        repeat (CPB) @(negedge clk);
        if (have && !e.skip) chk("stop_mid", tx, 1);
        repeat (CPB / 2 - 1) @(negedge clk);
        if (have && !e.skip) begin
          chk("stop_end", tx, 1);
          chk("frame_data", d, e.data);
          chk("frame_start", st, e.start);
        end
      end
    end
  end

  initial begin : stim
    int t0;

    // reset state, held while rst=1
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_idle", idle, 1);
      chk("rst_ovf", ovf, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_idle_tx", tx, 1);
      chk("rst_idle_idle", idle, 1);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // single byte 0x55
    t0 = cyc + 2;
    write_at(t0, 8'h55, 1, t0 + 1);
    wait_until(t0 + 1);
    chk("b55_start_tx", tx, 0);
    chk("b55_idle_low", idle, 0);
    wait_until(t0 + 101);
    chk("b55_bit0", tx, 1);
    wait_until(t0 + 201);
    chk("b55_bit1", tx, 0);
    wait_until(t0 + FL);
    chk("b55_idle_last_stop", idle, 0);
    wait_until(t0 + FL + 1);
    chk("b55_idle_back", idle, 1);
    chk("b55_tx_idle", tx, 1);

    // back-to-back 0xA5 then 0x3C written mid-frame
    t0 = cyc + 5;
    write_at(t0, 8'hA5, 1, t0 + 1);
    write_at(t0 + 300, 8'h3C, 1, t0 + FL + 1);
    wait_until(t0 + FL + 1);
    chk("b2b_second_start", tx, 0);
    chk("b2b_idle_mid", idle, 0);
    wait_until(t0 + 2 * FL);
    chk("b2b_idle_end", idle, 0);
    wait_until(t0 + 2 * FL + 1);
    chk("b2b_idle_back", idle, 1);

    // overflow: third write while buffer full is dropped
    t0 = cyc + 5;
    write_at(t0, 8'hC3, 1, t0 + 1);
    write_at(t0 + 10, 8'h1E, 1, t0 + FL + 1);
    @(negedge clk);
    chk("ovf_after_capture", ovf, 0);
    write_at(t0 + 20, 8'hFF, 0, 0);
    @(negedge clk);
    chk("ovf_pulse", ovf, 1);
    @(negedge clk);
    chk("ovf_one_cycle", ovf, 0);
    wait_until(t0 + 2 * FL + 2 * CPB);
    chk("ovf_two_frames", sb.size(), 0);
    chk("ovf_idle_after", idle, 1);

    // write on the final stop cycle while the buffer is full: nothing dropped
    t0 = cyc + 5;
    write_at(t0, 8'h96, 1, t0 + 1);
    write_at(t0 + 5, 8'h4B, 1, t0 + FL + 1);
    write_at(t0 + FL, 8'hE2, 1, t0 + 2 * FL + 1);
    @(negedge clk);
    chk("edge_no_ovf", ovf, 0);
    chk("edge_second_start", tx, 0);
    wait_until(t0 + 3 * FL + 1);
    chk("edge_idle_back", idle, 1);

    // 0x07: odd number of ones
    t0 = cyc + 5;
    write_at(t0, 8'h07, 1, t0 + 1);
`ifdef UART_PARITY_EN
    wait_until(t0 + 1 + 9 * CPB + CPB / 2);
    chk("b07_parity", tx, PODD ? 0 : 1);
    wait_until(t0 + 1 + 10 * CPB);
    chk("b07_stop_first", tx, 1);
`endif
    wait_until(t0 + FL + 1);
    chk("b07_idle_back", idle, 1);

    // reset in the middle of 0xF0 with 0x11 buffered
    t0 = cyc + 5;
    write_at(t0, 8'hF0, 2, t0 + 1);
    write_at(t0 + 5, 8'h11, 0, 0);
    wait_until(t0 + 450);
    chk("abort_pre_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("abort_tx_now", tx, 1);
    chk("abort_idle_now", idle, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_until(t0 + 450 + 2 * FL);
    chk("abort_idle_after", idle, 1);
    chk("abort_no_frames", sb.size(), 0);
    t0 = cyc + 5;
    write_at(t0, 8'h81, 1, t0 + 1);
    wait_until(t0 + FL + 2 * CPB);
    chk("b81_idle_back", idle, 1);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
